// File: rtl/temp_sensor_reader.sv
// Temperature sensor reader: polls a serial sensor every POLL_CYCLES idle
// cycles, clocks in one 8-bit frame MSB-first, checks the sync and parity
// fields, and publishes the 5-bit temperature with a valid or error pulse.
module temp_sensor_reader #(
  parameter int POLL_CYCLES = 100,
  parameter int SCLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       miso,
  output logic       cs_n,
  output logic       sclk,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       frame_err
);

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Sync field must be 2'b10 and frame[5:0] must carry even parity.
  function automatic logic frame_ok(input logic [7:0] frame);
    return (frame[7:6] == 2'b10) && ((^frame[5:0]) == 1'b0);
  endfunction

  state_e          state_q;
  logic [PW-1:0]   poll_cnt_q;
  logic [DW-1:0]   div_cnt_q;
  logic [3:0]      half_cnt_q;   // sclk half-period index within SHIFT, 0..15
  logic [7:0]      shift_q;
  logic            cs_n_q;
  logic            sclk_q;
  logic [4:0]      temp_q;
  logic            temp_valid_q;
  logic            frame_err_q;
  logic            frame_ok_d;

  assign frame_ok_d = frame_ok(shift_q);

  // Polling/frame state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      poll_cnt_q   <= '0;
      div_cnt_q    <= '0;
      half_cnt_q   <= 4'd0;
      shift_q      <= 8'd0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      temp_q       <= 5'd0;
      temp_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      // Pulses are single-cycle unless DONE re-asserts one below.
      temp_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cs_n_q <= 1'b1;
          sclk_q <= 1'b0;
          if (enable) begin
            if (poll_cnt_q == POLL_LAST) begin
              poll_cnt_q <= '0;
              div_cnt_q  <= '0;
              cs_n_q     <= 1'b0;
              state_q    <= ST_SELECT;
            end else begin
              poll_cnt_q <= poll_cnt_q + PW'(1);
            end
          end else begin
            poll_cnt_q <= '0;
          end
        end
        ST_SELECT: begin
          // Chip-select setup time with sclk held low.
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q  <= '0;
            half_cnt_q <= 4'd0;
            state_q    <= ST_SHIFT;
          end else begin
            div_cnt_q <= div_cnt_q + DW'(1);
          end
        end
        ST_SHIFT: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            if (half_cnt_q == 4'd15) begin
              // Final falling edge: leave with sclk low and deselect.
              half_cnt_q <= 4'd0;
              sclk_q     <= 1'b0;
              cs_n_q     <= 1'b1;
              state_q    <= ST_DONE;
            end else begin
              half_cnt_q <= half_cnt_q + 4'd1;
              sclk_q     <= ~sclk_q;
              if (!sclk_q) begin
                // Sample on the edge that drives sclk high.
                shift_q <= {shift_q[6:0], miso};
              end else begin
                shift_q <= shift_q;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + DW'(1);
          end
        end
        ST_DONE: begin
          cs_n_q     <= 1'b1;
          sclk_q     <= 1'b0;
          poll_cnt_q <= '0;
          if (frame_ok_d) begin
            temp_q       <= shift_q[5:1];
            temp_valid_q <= 1'b1;
          end else begin
            frame_err_q  <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          cs_n_q     <= 1'b1;
          sclk_q     <= 1'b0;
          poll_cnt_q <= '0;
          div_cnt_q  <= '0;
          half_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign cs_n        = cs_n_q;
  assign sclk        = sclk_q;
  assign temperature = temp_q;
  assign temp_valid  = temp_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: a behavioural sensor drives miso from a frame
// queue; frame acceptance and the published temperature are predicted from
// the frame format rules and compared at each step.
module tb_temp_sensor_reader;

  localparam int POLL = 100;
  localparam int SDIV = 4;
  localparam int LAT  = SDIV * (1 + 16) + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       miso;
  logic       cs_n;
  logic       sclk;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cs = -1;
  logic [4:0] model_temp = 5'd0;

  temp_sensor_reader #(.POLL_CYCLES(POLL), .SCLK_DIV(SDIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .miso(miso),
    .cs_n(cs_n), .sclk(sclk), .temperature(temperature),
    .temp_valid(temp_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Count rising clk edges as the bench's time base.
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model: load a frame on chip-select, advance one bit per sclk rise.
  logic [7:0] sensor_q[$];
  logic [7:0] cur_frame = 8'd0;
  logic [3:0] rise_cnt = 4'd8;
  always @(negedge cs_n or posedge sclk) begin
    if (sclk) begin
      rise_cnt <= rise_cnt + 4'd1;
    end else begin
      if (sensor_q.size() > 0) cur_frame <= sensor_q.pop_front();
      else cur_frame <= 8'd0;
      rise_cnt <= 4'd0;
    end
  end
  assign miso = (rise_cnt < 4'd8) ? cur_frame[3'(4'd7 - rise_cnt)] : 1'b0;

  function automatic bit frame_good(input logic [7:0] f);
    return (f[7:6] == 2'b10) && (($countones(f[5:0]) % 2) == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run one frame: wait for chip select, watch sclk, then check the outcome.
  task automatic do_frame(input logic [7:0] f, input int drop_rise,
                          input bit chk_gap, input int exp_wait);
    int start, cs_cyc, rises, hlen, n;
    bit got, exp_ok;
    logic prev;
    start = cyc;
    sensor_q.push_back(f);
    got = 0;
    n = 0;
    while (!got && n < POLL + 200) begin
      @(negedge clk);
      n++;
      if (cs_n === 1'b0) got = 1;
    end
    check("cs_fall_seen", 32'(got), 32'd1);
    if (!got) return;
    cs_cyc = cyc;
    if (exp_wait >= 0) check("poll_wait", 32'(cs_cyc - start), 32'(exp_wait));
    if (chk_gap && last_cs >= 0) check("cs_gap", 32'(cs_cyc - last_cs), 32'(POLL + LAT - 1));
    last_cs = cs_cyc;
    rises = 0;
    hlen = 0;
    prev = 1'b0;
    got = 0;
    n = 0;
    while (!got && n < LAT + 20) begin
      @(negedge clk);
      n++;
      if (sclk === 1'b1) begin
        if (!prev) rises++;
        hlen++;
      end else if (prev) begin
        check("sclk_high_len", 32'(hlen), 32'(SDIV));
        hlen = 0;
      end
      prev = sclk;
      if (drop_rise > 0 && rises == drop_rise) enable = 1'b0;
      if (temp_valid === 1'b1 || frame_err === 1'b1) got = 1;
    end
    check("pulse_seen", 32'(got), 32'd1);
    if (!got) return;
    exp_ok = frame_good(f);
    if (exp_ok) model_temp = f[5:1];
    check("latency", 32'(cyc - cs_cyc + 1), 32'(LAT));
    check("sclk_rises", 32'(rises), 32'd8);
    check("temp_valid", 32'(temp_valid), 32'(exp_ok));
    check("frame_err", 32'(frame_err), 32'(!exp_ok));
    check("temperature", 32'(temperature), 32'(model_temp));
    check("cs_n_done", 32'(cs_n), 32'd1);
    @(negedge clk);
    check("pulse_width", 32'({temp_valid, frame_err}), 32'd0);
    check("temp_hold", 32'(temperature), 32'(model_temp));
  endtask

  initial begin
    int lows, n, rises;
    bit got, pulse;
    logic prev;
    logic [4:0] t;
    logic [7:0] f;

    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_temp", 32'(temperature), 32'd0);
    check("rst_valid", 32'(temp_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;

    // Disabled: no frame may start.
    lows = 0;
    repeat (2 * POLL) begin
      @(negedge clk);
      if (cs_n !== 1'b1) lows++;
    end
    check("idle_disabled", 32'(lows), 32'd0);

    // Directed frames: good 18, parity error, sync error, boundaries 0 and 31.
    enable = 1'b1;
    do_frame(8'b10_10010_0, 0, 0, POLL);
    do_frame(8'b10_10110_0, 0, 1, -1);
    do_frame(8'b01_00000_0, 0, 1, -1);
    do_frame(8'b10_00000_0, 0, 1, -1);
    do_frame(8'b10_11111_1, 0, 1, -1);

    // Random frames, alternating well-formed and arbitrary.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        t = 5'($urandom_range(0, 31));
        f = {2'b10, t, 1'($countones(t) % 2)};
      end else begin
        f = 8'($urandom);
      end
      do_frame(f, 0, 1, -1);
    end

    // Enable dropped after the 3rd sclk rise: frame completes, then silence.
    do_frame(8'b10_01101_1, 3, 1, -1);
    lows = 0;
    repeat (3 * POLL) begin
      @(negedge clk);
      if (cs_n !== 1'b1) lows++;
    end
    check("no_cs_while_disabled", 32'(lows), 32'd0);
    enable = 1'b1;
    do_frame(8'b10_00110_0, 0, 0, POLL);

    // Reset after the 5th sclk rise aborts the frame.
    sensor_q.push_back(8'b10_11111_1);
    got = 0;
    n = 0;
    while (!got && n < POLL + 200) begin
      @(negedge clk);
      n++;
      if (cs_n === 1'b0) got = 1;
    end
    check("abort_cs_fall_seen", 32'(got), 32'd1);
    rises = 0;
    prev = 1'b0;
    pulse = 0;
    n = 0;
    while (rises < 5 && n < LAT) begin
      @(negedge clk);
      n++;
      if (sclk === 1'b1 && !prev) rises++;
      prev = sclk;
      if (temp_valid === 1'b1 || frame_err === 1'b1) pulse = 1;
    end
    check("abort_rises", 32'(rises), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    model_temp = 5'd0;
    check("abort_cs_n", 32'(cs_n), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_temp", 32'(temperature), 32'(model_temp));
    repeat (3) begin
      @(negedge clk);
      if (temp_valid === 1'b1 || frame_err === 1'b1) pulse = 1;
    end
    check("abort_no_pulse", 32'(pulse), 32'd0);
    rst_n = 1'b1;
    do_frame(8'b10_10010_0, 0, 0, POLL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/temp_sensor_reader.md
TEMP_SENSOR_READER -- requirements
Module: temp_sensor_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter POLL_CYCLES, default 100: SHALL set the number of clk cycles spent in IDLE between frames.
REQ-003 Parameter SCLK_DIV, default 4: SHALL set the number of clk cycles per sclk half-period, minimum 2.
REQ-004 Port clk, input, 1 bit: system clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port enable, input, 1 bit: when high, polling is allowed.
REQ-007 Port miso, input, 1 bit: serial data from the sensor.
REQ-008 Port cs_n, output, 1 bit: sensor chip select, active low.
REQ-009 Port sclk, output, 1 bit: serial clock to the sensor; idles low.
REQ-010 Port temperature, output, 5 bits: last good reading, unsigned, feeding the heating/cooling controller.
REQ-011 Port temp_valid, output, 1 bit: one-cycle pulse when temperature is updated.
REQ-012 Port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected.

Function
REQ-013 The state machine SHALL have the states IDLE, SELECT, SHIFT and DONE.
REQ-014 IDLE: cs_n=1, sclk=0; the poll counter increments while enable=1 and clears while enable=0; on reaching POLL_CYCLES-1 the block SHALL go to SELECT and clear the counter.
REQ-015 SELECT: cs_n=0, sclk=0 for SCLK_DIV cycles (setup time), then the block SHALL go to SHIFT.
REQ-016 SHIFT: sclk SHALL toggle every SCLK_DIV cycles, giving exactly 8 rising edges, period 2*SCLK_DIV clk cycles, starting low.
REQ-017 miso SHALL be shifted in MSB-first on the clk edge at which sclk is driven 0->1, so 8 bits frame[7:0] are captured.
REQ-018 After the 8th falling edge of sclk the block SHALL go to DONE; sclk SHALL be 0 on exit from SHIFT.
REQ-019 DONE lasts 1 cycle with cs_n=1; the frame is evaluated and the block SHALL then return to IDLE.
REQ-020 Frame format: frame[7:6] = sync (must be 2'b10); frame[5:1] = temperature, MSB first; frame[0] = even parity, so that XOR(frame[5:0]) = 0.
REQ-021 If the sync and parity are both correct, then on the cycle after DONE temperature SHALL equal frame[5:1] and temp_valid SHALL be 1 for exactly one cycle.
REQ-022 If the sync or parity is wrong, frame_err SHALL pulse for one cycle, temperature SHALL hold, and temp_valid SHALL stay 0.
REQ-023 temp_valid and frame_err SHALL never be asserted together.
REQ-024 If enable is deasserted during SELECT or SHIFT, the current frame SHALL complete normally; the block then stays in IDLE until enable returns.
REQ-025 After enable rises, the first cs_n falling edge SHALL occur exactly POLL_CYCLES cycles later.
REQ-026 The poll counter and bit counter SHALL wrap only through the transitions above; there is no free-running wrap.
REQ-027 Latency from cs_n falling to the temp_valid pulse SHALL be SCLK_DIV*(1+16)+2 clk cycles (70 at default).

Reset
REQ-028 On rst_n=0, asynchronously: state=IDLE, cs_n=1, sclk=0, temperature=5'd0, temp_valid=0, frame_err=0, and all counters and the shift register cleared.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no valid or error pulse; after release the block SHALL wait a full POLL_CYCLES before the next frame.

Verification
REQ-030 Good frame: enable=1, sensor returns 8'b10_10010_0 -> temperature=18, one temp_valid pulse, 8 sclk rising edges, each high phase 4 cycles.
REQ-031 Parity error: sensor returns 8'b10_10110_0 -> frame_err pulse, temperature holds its previous value of 18, no temp_valid.
REQ-032 Sync error: sensor returns 8'b01_00000_0 -> frame_err pulse, temperature unchanged.
REQ-033 Boundary values: frames carrying 0 and 31 (8'b10_11111_1) -> temperature 0 and 31; back-to-back cs_n falling edges are POLL_CYCLES+70-1 cycles apart (check against RTL).
REQ-034 Drop enable after the 3rd sclk rise -> the frame completes with a temp_valid pulse, and no further cs_n low while enable=0.
REQ-035 rst_n pulsed low after the 5th sclk rise -> cs_n=1 and sclk=0 within the same cycle, no pulses, temperature=0.
